// File: rtl/parity_checker_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Optional saturating error counter is built when PARITY_CHECKER_ERR_CNT_EN is defined.
module parity_checker_rx #(
   parameter int DATA_W     = 3,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sin,
   input  logic              bit_en,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
`ifdef PARITY_CHECKER_ERR_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   function automatic logic expected_parity(input logic [DATA_W-1:0] d);
      return (^d) ^ (PARITY_ODD != 0);
   endfunction

`ifdef PARITY_CHECKER_ERR_CNT_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction
`endif

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              par_q, par_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              parity_err_q, parity_err_d;
   logic              frame_err_q, frame_err_d;
   logic              frame_bad;
`ifdef PARITY_CHECKER_ERR_CNT_EN
   logic [7:0]        err_cnt_q, err_cnt_d;
`endif

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      frame_bad    = 1'b0;
`ifdef PARITY_CHECKER_ERR_CNT_EN
      err_cnt_d    = err_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bit_en && !sin) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (bit_en) begin
               shreg_d[bit_cnt_q] = sin;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = S_PARITY;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_en) begin
               par_d   = sin;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Frame completes here; returning straight to IDLE means this
            // strobe can never double as the next start bit.
            if (bit_en) begin
               state_d      = S_IDLE;
               dout_d       = shreg_q;
               dout_valid_d = 1'b1;
               parity_err_d = (par_q != expected_parity(shreg_q));
               frame_err_d  = !sin;
               frame_bad    = parity_err_d || frame_err_d;
`ifdef PARITY_CHECKER_ERR_CNT_EN
               if (frame_bad) err_cnt_d = sat_inc(err_cnt_q);
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef PARITY_CHECKER_ERR_CNT_EN
         err_cnt_q    <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
`ifdef PARITY_CHECKER_ERR_CNT_EN
         err_cnt_q    <= err_cnt_d;
`endif
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign busy       = (state_q != S_IDLE);
`ifdef PARITY_CHECKER_ERR_CNT_EN
   assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_checker_rx.sv
// Scoreboard bench for parity_checker_rx: an even and an odd instance see the same line.
// Error-counter checks are built when PARITY_CHECKER_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_parity_checker_rx;

   localparam int BIT_GAP = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sin;
   logic       bit_en;
   logic [2:0] dout_e, dout_o;
   logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;
`ifdef PARITY_CHECKER_ERR_CNT_EN
   logic [7:0] cnt_e, cnt_o;
`endif

   typedef struct {
      logic [2:0] d;
      logic       pe;
      logic       fe;
      logic [7:0] cnt;
   } exp_t;

   exp_t q_even[$];
   exp_t q_odd[$];
   int   checks = 0;
   int   errors = 0;
   logic [7:0] exp_cnt_e = 8'd0;
   logic [7:0] exp_cnt_o = 8'd0;

   always #5 clk = ~clk;

   parity_checker_rx #(.DATA_W(3), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en),
      .dout(dout_e), .dout_valid(dv_e), .parity_err(pe_e), .frame_err(fe_e), .busy(busy_e)
`ifdef PARITY_CHECKER_ERR_CNT_EN
      , .err_cnt(cnt_e)
`endif
   );

   parity_checker_rx #(.DATA_W(3), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst(rst), .sin(sin), .bit_en(bit_en),
      .dout(dout_o), .dout_valid(dv_o), .parity_err(pe_o), .frame_err(fe_o), .busy(busy_o)
`ifdef PARITY_CHECKER_ERR_CNT_EN
      , .err_cnt(cnt_o)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: pops one expectation per dout_valid pulse.
   always @(negedge clk) begin
      exp_t e;
      if (dv_e) begin
         if (q_even.size() == 0) begin
            checks++; errors++;
            $display("FAIL even_unexpected_pulse: got dout %0h expected no pulse at %0t", dout_e, $time);
         end else begin
            e = q_even.pop_front();
            chk("even_dout", 32'(dout_e), 32'(e.d));
            chk("even_parity_err", 32'(pe_e), 32'(e.pe));
            chk("even_frame_err", 32'(fe_e), 32'(e.fe));
`ifdef PARITY_CHECKER_ERR_CNT_EN
            chk("even_err_cnt", 32'(cnt_e), 32'(e.cnt));
`endif
         end
      end
      if (dv_o) begin
         if (q_odd.size() == 0) begin
            checks++; errors++;
            $display("FAIL odd_unexpected_pulse: got dout %0h expected no pulse at %0t", dout_o, $time);
         end else begin
            e = q_odd.pop_front();
            chk("odd_dout", 32'(dout_o), 32'(e.d));
            chk("odd_parity_err", 32'(pe_o), 32'(e.pe));
            chk("odd_frame_err", 32'(fe_o), 32'(e.fe));
`ifdef PARITY_CHECKER_ERR_CNT_EN
            chk("odd_err_cnt", 32'(cnt_o), 32'(e.cnt));
`endif
         end
      end
   end

   task automatic send_bit(input logic b);
      sin    = b;
      bit_en = 1'b1;
      @(negedge clk);
      bit_en = 1'b0;
      repeat (BIT_GAP - 1) @(negedge clk);
   endtask

   // pe_ev / pe_od are hand-computed parity_err values for the even / odd instance.
   task automatic send_frame(input logic [2:0] d, input logic p, input logic s,
                             input logic pe_ev, input logic pe_od);
      exp_t e;
      if ((pe_ev || !s) && exp_cnt_e != 8'hFF) exp_cnt_e = exp_cnt_e + 8'd1;
      if ((pe_od || !s) && exp_cnt_o != 8'hFF) exp_cnt_o = exp_cnt_o + 8'd1;
      e.d = d; e.pe = pe_ev; e.fe = !s; e.cnt = exp_cnt_e;
      q_even.push_back(e);
      e.pe = pe_od; e.cnt = exp_cnt_o;
      q_odd.push_back(e);
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      send_bit(p);
      send_bit(s);
      sin = 1'b1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sin    = 1'b1;
      bit_en = 1'b0;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_dout", 32'(dout_e), 32'd0);
      chk("reset_valid", 32'(dv_e | dv_o), 32'd0);
      chk("reset_flags", 32'({pe_e, fe_e, pe_o, fe_o}), 32'd0);
      chk("reset_busy", 32'({busy_e, busy_o}), 32'd0);
`ifdef PARITY_CHECKER_ERR_CNT_EN
      chk("reset_err_cnt", 32'({cnt_e, cnt_o}), 32'd0);
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);

      send_frame(3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(3'b011, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      chk("hold_dout", 32'(dout_e), 32'h3);
      chk("hold_parity_err", 32'(pe_e), 32'd1);
      chk("hold_busy", 32'(busy_e), 32'd0);
      // Stop bit 0 must not be taken as the next start bit.
      send_frame(3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(3'b111, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(3'b111, 1'b1, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a frame.
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      chk("midframe_busy", 32'(busy_e), 32'd1);
      #2 rst = 1'b1;
      #1 chk("async_reset_busy", 32'({busy_e, busy_o}), 32'd0);
      chk("async_reset_dout", 32'(dout_e), 32'd0);
      exp_cnt_e = 8'd0;
      exp_cnt_o = 8'd0;
      @(negedge clk);
      rst = 1'b0;
      sin = 1'b1;
      repeat (10) @(negedge clk);
      send_frame(3'b100, 1'b1, 1'b1, 1'b0, 1'b1);

`ifdef PARITY_CHECKER_ERR_CNT_EN
      for (int n = 0; n < 260; n++) send_frame(3'b000, 1'b1, 1'b1, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      chk("sat_err_cnt", 32'(cnt_e), 32'd255);
`endif

      sin = 1'b0;
      bit_en = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         chk("idle_busy", 32'({busy_e, busy_o}), 32'd0);
      end
      sin = 1'b1;

      for (int c = 0; c < 20 && (q_even.size() + q_odd.size()) != 0; c++) @(negedge clk);
      chk("scoreboard_drained", 32'(q_even.size() + q_odd.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
